// File: rtl/td4_port_in_conditioner.sv
// td4_port_in_conditioner
//
// Input-port front end for the TD4 CPU. Each of the WIDTH board switch/button
// levels passes through its own SYNC_STAGES-deep synchroniser and is then
// debounced independently. A synchronised bit has to disagree with its accepted
// value for DEBOUNCE consecutive clocks before the new value is taken. When an
// acceptance happens, the bit also fires a one-cycle rise or fall strobe.
//
// Parameter constraints: SYNC_STAGES >= 2, DEBOUNCE >= 1, 2**CNT_W > DEBOUNCE.
//
// Ports:
//   clk      - CPU system clock; all state updates on its rising edge
//   n_reset  - asynchronous active-low reset; clears every flop
//   raw_in   - asynchronous switch/button levels from the board pins
//   port_in  - debounced, registered value for the CPU's IN A / IN B
//   rise     - one-cycle pulse per bit on an accepted 0->1 change
//   fall     - one-cycle pulse per bit on an accepted 1->0 change
//   changed  - registered OR of rise and fall; coincident with any pulse
//
// Every output comes from a flop, so there is no combinational path from
// raw_in to any output.

module td4_port_in_conditioner #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 50000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] port_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0]                  s;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_p1;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0]            port_nxt;
  logic [WIDTH-1:0]            rise_nxt;
  logic [WIDTH-1:0]            fall_nxt;
  logic                        changed_nxt;

  // Stage p0: synchroniser chain. Each stage is a plain flop with no logic
  // between stages, so metastability has a full clock period to resolve.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_p0[SYNC_STAGES-1];

  // Stage p1: per-bit debounce. The counter only runs while s disagrees with
  // the accepted value. It clears on the acceptance cycle, so it never goes
  // past CNT_MAX and cannot wrap.
  always_comb begin
    port_nxt = port_in;
    rise_nxt = '0;
    fall_nxt = '0;
    cnt_nxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] != port_in[i]) begin
        if (cnt_p1[i] == CNT_MAX) begin
          port_nxt[i] = s[i];
          rise_nxt[i] = s[i];
          fall_nxt[i] = ~s[i];
        end else begin
          cnt_nxt[i] = cnt_p1[i] + CNT_W'(1);
        end
      end
    end
  end

  // changed is derived from the next-state strobes rather than the registered
  // ones. This lines it up with the rise/fall pulse instead of lagging by one
  // cycle.
  assign changed_nxt = |(rise_nxt | fall_nxt);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_p1  <= '0;
      port_in <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      cnt_p1  <= cnt_nxt;
      port_in <= port_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      changed <= changed_nxt;
    end
  end

endmodule

// File: tb/tb_td4_port_in_conditioner.sv
// Directed bench for td4_port_in_conditioner with WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE=4. Inputs change 1 time unit after a rising edge, and outputs are
// sampled at the same point. An accepted change therefore shows up after
// exactly 6 ticks.

module tb_td4_port_in_conditioner;

  logic       clk;
  logic       n_reset;
  logic [3:0] raw_in;
  logic [3:0] port_in;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;

  int vectors;
  int miscompares;

  td4_port_in_conditioner #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .DEBOUNCE   (4),
    .CNT_W      (16)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .raw_in (raw_in),
    .port_in(port_in),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    raw_in  = 4'b0101;
    tick();
    tick();
    vectors++;
    if ({port_in, rise, fall, changed} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got port_in=%b rise=%b fall=%b changed=%b want all 0",
               port_in, rise, fall, changed);
    end
    n_reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (port_in !== 4'b0000 || rise !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_latency tick %0d: got port_in=%b rise=%b want 0000/0000",
                 k, port_in, rise);
      end
    end
    tick();
    vectors++;
    if (port_in !== 4'b0101 || rise !== 4'b0101 || fall !== 4'b0000 || changed !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_accept: got port_in=%b rise=%b fall=%b changed=%b want 0101/0101/0000/1",
               port_in, rise, fall, changed);
    end
    tick();
    vectors++;
    if (port_in !== 4'b0101 || rise !== 4'b0000 || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulse_end: got port_in=%b rise=%b changed=%b want 0101/0000/0",
               port_in, rise, changed);
    end
  endtask

  task automatic test_step();
    raw_in = 4'b0111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (port_in !== 4'b0101 || changed !== 1'b0) begin
        miscompares++;
        $display("FAIL step_wait tick %0d: got port_in=%b changed=%b want 0101/0",
                 k, port_in, changed);
      end
    end
    tick();
    vectors++;
    if (port_in !== 4'b0111 || rise !== 4'b0010 || fall !== 4'b0000 || changed !== 1'b1) begin
      miscompares++;
      $display("FAIL step_accept: got port_in=%b rise=%b fall=%b changed=%b want 0111/0010/0000/1",
               port_in, rise, fall, changed);
    end
    tick();
    vectors++;
    if (rise !== 4'b0000 || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL step_pulse_end: got rise=%b changed=%b want 0000/0", rise, changed);
    end
  endtask

  task automatic test_glitch();
    raw_in = 4'b1111;
    tick();
    tick();
    tick();
    raw_in = 4'b0111;
    for (int k = 1; k <= 10; k++) begin
      tick();
      vectors++;
      if (port_in !== 4'b0111 || rise !== 4'b0000 || fall !== 4'b0000 || changed !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch tick %0d: got port_in=%b rise=%b fall=%b changed=%b want 0111/0000/0000/0",
                 k, port_in, rise, fall, changed);
      end
    end
  endtask

  task automatic test_bounce();
    raw_in = 4'b0110;
    tick();
    raw_in = 4'b0111;
    tick();
    raw_in = 4'b0110;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (port_in !== 4'b0111 || fall !== 4'b0000) begin
        miscompares++;
        $display("FAIL bounce_wait tick %0d: got port_in=%b fall=%b want 0111/0000",
                 k, port_in, fall);
      end
    end
    tick();
    vectors++;
    if (port_in !== 4'b0110 || fall !== 4'b0001 || rise !== 4'b0000 || changed !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_accept: got port_in=%b fall=%b rise=%b changed=%b want 0110/0001/0000/1",
               port_in, fall, rise, changed);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      vectors++;
      if (port_in !== 4'b0110 || fall !== 4'b0000 || changed !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_settled tick %0d: got port_in=%b fall=%b changed=%b want 0110/0000/0",
                 k, port_in, fall, changed);
      end
    end
  endtask

  task automatic test_simultaneous();
    raw_in = 4'b0000;
    for (int k = 1; k <= 8; k++) tick();
    vectors++;
    if (port_in !== 4'b0000) begin
      miscompares++;
      $display("FAIL simul_clear: got port_in=%b want 0000", port_in);
    end
    raw_in = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (port_in !== 4'b0000 || changed !== 1'b0) begin
        miscompares++;
        $display("FAIL simul_wait tick %0d: got port_in=%b changed=%b want 0000/0",
                 k, port_in, changed);
      end
    end
    tick();
    vectors++;
    if (port_in !== 4'b1111 || rise !== 4'b1111 || fall !== 4'b0000 || changed !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_accept: got port_in=%b rise=%b fall=%b changed=%b want 1111/1111/0000/1",
               port_in, rise, fall, changed);
    end
    tick();
    vectors++;
    if (rise !== 4'b0000 || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_pulse_end: got rise=%b changed=%b want 0000/0", rise, changed);
    end
  endtask

  task automatic test_midreset();
    raw_in = 4'b0011;
    for (int k = 1; k <= 8; k++) tick();
    vectors++;
    if (port_in !== 4'b0011) begin
      miscompares++;
      $display("FAIL midreset_setup: got port_in=%b want 0011", port_in);
    end
    raw_in = 4'b0111;
    tick();
    tick();
    n_reset = 1'b0;
    #1;
    vectors++;
    if (port_in !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000 || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async: got port_in=%b rise=%b fall=%b changed=%b want 0000/0000/0000/0",
               port_in, rise, fall, changed);
    end
    tick();
    tick();
    n_reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (port_in !== 4'b0000 || changed !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_wait tick %0d: got port_in=%b changed=%b want 0000/0",
                 k, port_in, changed);
      end
    end
    tick();
    vectors++;
    if (port_in !== 4'b0111 || rise !== 4'b0111 || changed !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_accept: got port_in=%b rise=%b changed=%b want 0111/0111/1",
               port_in, rise, changed);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_reset     = 1'b0;
    raw_in      = 4'b0000;
    test_reset();
    test_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
